// File: rtl/reg_file_buffered.sv
// reg_file_buffered
//   General-purpose register file for the 8-bit CPU datapath with two
//   combinational read ports and a one-entry pending-write buffer. A write
//   that arrives while the memory system is stalled (BUSY) is parked in the
//   buffer and retired into the array once BUSY drops.
//
// Parameters
//   WIDTH    bits per register
//   DEPTH    number of registers (power of 2, >= 2)
//   AW       address width, derived from DEPTH (do not override)
//   BYPASS   1 = a write accepted this cycle is forwarded to the read ports
//   ZERO_REG 1 = register 0 reads as 0 and writes to it are dropped
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RESET        synchronous active-low reset
//   IN           write data
//   INADDRESS    write address
//   WRITE        write request
//   BUSY         memory stall, array may not be written while high
//   OUT1ADDRESS  read port 1 address
//   OUT2ADDRESS  read port 2 address
//   OUT1         read port 1 data (combinational)
//   OUT2         read port 2 data (combinational)
//   PENDING      pending-write buffer occupied (registered)
//   STALL        write cannot be accepted this cycle (PENDING & BUSY)

module reg_file_buffered #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    INADDRESS,
    input  logic             WRITE,
    input  logic             BUSY,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    output logic             PENDING,
    output logic             STALL
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             pending;
    logic [AW-1:0]    buf_addr;
    logic [WIDTH-1:0] buf_data;

    logic             accept;
    logic             discard;
    logic             accept_store;

    // A write is taken whenever the buffer is not both full and blocked.
    // Writes to a hardwired-zero r0 are taken (so the requester moves on)
    // but never reach the array or the buffer.
    always_comb begin
        STALL        = pending & BUSY;
        accept       = WRITE & ~STALL & RESET;
        discard      = (ZERO_REG != 0) && (INADDRESS == '0);
        accept_store = accept & ~discard;
        PENDING      = pending;
    end

    // State update. The retire and the direct write are both issued as
    // non-blocking assignments in this order, so when they hit the same
    // register the newer direct write is the one that lands.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            if (!BUSY && pending) begin
                mem[buf_addr] <= buf_data;
                pending       <= 1'b0;
            end
            if (!BUSY && accept_store) begin
                mem[INADDRESS] <= IN;
            end
            if (BUSY && !pending && accept_store) begin
                buf_addr <= INADDRESS;
                buf_data <= IN;
                pending  <= 1'b1;
            end
        end
    end

    // Read port 1: zero register, then same-cycle forward, then the
    // buffered write (newer than the array), then the array itself.
    always_comb begin
        OUT1 = mem[OUT1ADDRESS];
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end else if ((BYPASS != 0) && accept && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end else if (pending && (buf_addr == OUT1ADDRESS)) begin
            OUT1 = buf_data;
        end
    end

    // Read port 2: same priority order as port 1.
    always_comb begin
        OUT2 = mem[OUT2ADDRESS];
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end else if ((BYPASS != 0) && accept && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end else if (pending && (buf_addr == OUT2ADDRESS)) begin
            OUT2 = buf_data;
        end
    end

endmodule
